// File: rtl/bbox_pixel_walker_if.sv
// Bundle of the bbox-in / pixel-out signals of bbox_pixel_walker.
// The walker takes the slave modport; whoever feeds boxes and consumes pixels takes master.
interface bbox_pixel_walker_if #(
    parameter int COORD_W = 10
);
    logic               nd;
    logic               us_rfd;
    logic [COORD_W-1:0] min_x;
    logic [COORD_W-1:0] min_y;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] max_y;
    logic               ds_rfd;
    logic               rdy;
    logic [15:0]        p_x;
    logic [15:0]        p_y;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               last;
    logic               done;

    modport master (
        output nd, min_x, min_y, max_x, max_y, ds_rfd,
        input  us_rfd, rdy, p_x, p_y, pix_x, pix_y, last, done
    );

    modport slave (
        input  nd, min_x, min_y, max_x, max_y, ds_rfd,
        output us_rfd, rdy, p_x, p_y, pix_x, pix_y, last, done
    );
endinterface

// File: rtl/bbox_pixel_walker.sv
// Walks one screen-space bounding box in raster order and emits each pixel as FP16 and integer
// coordinates. Define PIXEL_CENTER_EN to encode p_x/p_y as the pixel centre (v + 0.5).
module bbox_pixel_walker #(
    parameter int COORD_W = 10
) (
    input logic                 clk,
    input logic                 rst,
    bbox_pixel_walker_if.slave  bus
);
    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;
    logic [COORD_W-1:0] min_x_q, min_x_d;
    logic [COORD_W-1:0] max_x_q, max_x_d;
    logic [COORD_W-1:0] max_y_q, max_y_d;
    logic               done_q, done_d;
    logic               at_row_end;
    logic               at_bbox_end;
    logic               xfer;

    // Positive integer w to FP16; in centre mode w holds 2v+1, so the exponent is one lower.
    function automatic logic [15:0] fp16_of(input logic [10:0] w, input logic centre);
        logic [3:0] e;
        logic [4:0] ex;
        logic [9:0] mant;
        e = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (w[i]) e = 4'(i);
        end
        mant = 10'(w << (4'd10 - e));
        ex   = centre ? (5'd14 + {1'b0, e}) : (5'd15 + {1'b0, e});
        if (w == 11'd0) fp16_of = 16'h0000;
        else            fp16_of = {1'b0, ex, mant};
    endfunction

    assign at_row_end  = (cx_q == max_x_q);
    assign at_bbox_end = at_row_end && (cy_q == max_y_q);
    assign xfer        = (state_q == SCAN) && bus.ds_rfd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            min_x_q <= '0;
            max_x_q <= '0;
            max_y_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            max_y_q <= max_y_d;
            done_q  <= done_d;
        end
    end

    // Empty boxes never enter SCAN; they only earn the done pulse so upstream can move on.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        min_x_d = min_x_q;
        max_x_d = max_x_q;
        max_y_d = max_y_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.nd) begin
                    if ((bus.min_x > bus.max_x) || (bus.min_y > bus.max_y)) begin
                        done_d = 1'b1;
                    end else begin
                        min_x_d = bus.min_x;
                        max_x_d = bus.max_x;
                        max_y_d = bus.max_y;
                        cx_d    = bus.min_x;
                        cy_d    = bus.min_y;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (xfer) begin
                    if (!at_row_end) begin
                        cx_d = cx_q + COORD_W'(1);
                    end else if (!at_bbox_end) begin
                        cx_d = min_x_q;
                        cy_d = cy_q + COORD_W'(1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.us_rfd = (state_q == IDLE);
    assign bus.rdy    = (state_q == SCAN);
    assign bus.last   = (state_q == SCAN) && at_bbox_end;
    assign bus.done   = done_q;
    assign bus.pix_x  = cx_q;
    assign bus.pix_y  = cy_q;

`ifdef PIXEL_CENTER_EN
    assign bus.p_x = fp16_of((11'(cx_q) << 1) | 11'd1, 1'b1);
    assign bus.p_y = fp16_of((11'(cy_q) << 1) | 11'd1, 1'b1);
`else
    assign bus.p_x = fp16_of(11'(cx_q), 1'b0);
    assign bus.p_y = fp16_of(11'(cy_q), 1'b0);
`endif

endmodule
